// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write path: address width, default
// data width and the grant-index width used by the write-port arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_W     = 32;
  // Wide enough for any NREQ up to 8.
  localparam int unsigned GRANT_W    = 3;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and ascends modulo NREQ.
// After a taken grant to i the pointer moves to i+1.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_i,
  input  logic               advance_i,
  output logic [NREQ-1:0]    grant_c_o,
  output logic [GRANT_W-1:0] grant_idx_c_o
);

  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]    upper_c;
  logic [GRANT_W-1:0] lo_idx_c, up_idx_c;
  logic               any_c;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    upper_c  = '0;
    lo_idx_c = '0;
    up_idx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      upper_c[i] = req_i[i] && (i >= 32'(ptr_q));
    end
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_i[i])   lo_idx_c = GRANT_W'(i);
      if (upper_c[i]) up_idx_c = GRANT_W'(i);
    end
    grant_idx_c_o = (|upper_c) ? up_idx_c : lo_idx_c;
    any_c         = reset && (|req_i);
    grant_c_o     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_c_o[i] = any_c && (grant_idx_c_o == GRANT_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_c) begin
      ptr_d = (grant_idx_c_o == GRANT_W'(NREQ - 1)) ? '0 : grant_idx_c_o + GRANT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Sole driver of the register file write port: arbitrates NREQ writeback
// sources and registers the winner; writes to register 0 are dropped and counted.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N     = DATA_W,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [REG_ADDR_W*NREQ-1:0] req_addr_i,
  input  logic [N*NREQ-1:0]          req_data_i,
  output logic                       Reg_Write_o,
  output logic [REG_ADDR_W-1:0]      Write_Register_o,
  output logic [N-1:0]               Write_Data_o,
  output logic [GRANT_W-1:0]         grant_id_o,
  output logic [CNT_W-1:0]           zero_drop_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREQ-1:0]    grant_c;
  logic [GRANT_W-1:0] grant_idx_c;
  logic               accept_c;
  reg_addr_t          sel_addr_c;
  logic [N-1:0]       sel_data_c;

  logic               we_q, we_d;
  reg_addr_t          waddr_q, waddr_d;
  logic [N-1:0]       wdata_q, wdata_d;
  logic [GRANT_W-1:0] gid_q, gid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req_valid_i),
    .advance_i     (accept_c),
    .grant_c_o     (grant_c),
    .grant_idx_c_o (grant_idx_c)
  );

  assign accept_c    = |grant_c;
  assign req_ready_o = grant_c;

  // One-hot AND-OR mux of the winning request payload.
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_addr_c = req_addr_i[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data_c = req_data_i[N*i +: N];
      end
    end
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    if (accept_c) begin
      gid_d = grant_idx_c;
      if (sel_addr_c != ZERO_REG) begin
        we_d    = 1'b1;
        waddr_d = sel_addr_c;
        wdata_d = sel_data_c;
      end else begin
        waddr_d = ZERO_REG;
        wdata_d = '0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Reg_Write_o      = we_q;
  assign Write_Register_o = waddr_q;
  assign Write_Data_o     = wdata_q;
  assign grant_id_o       = gid_q;
  assign zero_drop_cnt_o  = cnt_q;

endmodule
